pcie_egress_splitter: RTL and testbench

- Sits directly upstream of the PCIe egress TLP builder.
- Accepts one host-buffer transfer request (base address, total dword count, read or write) and breaks it into a sequence of 32-bit-address TLP requests.
- Each chunk is limited by the max payload size and must not cross a 4 KB boundary.
- Drives the builder's enable/finished handshake once per chunk and supplies command, flags, address, requester ID, tag and per-TLP dword count.

---
 rtl/pcie_egress_splitter.sv | 178 +++++++++++++++++
 tb/tb_pcie_egress_splitter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_egress_splitter.sv
// pcie_egress_splitter: breaks one host-buffer transfer into a sequence of
// 32-bit-address MWR/MRD TLP requests for the egress TLP builder. Each chunk
// is bounded by the max payload/read size and never crosses a 4 KB page.
// Optional feature macro: PCIE_SPLIT_STATS_EN (per-transfer TLP counter on
// o_tlp_count; tied to 0 when undefined).
module pcie_egress_splitter #(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int MAX_READ_DW    = 128,
  parameter int CNT_WIDTH      = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_cmd_write,
  input  logic [31:0]          i_base_address,
  input  logic [CNT_WIDTH-1:0] i_total_dwords,
  input  logic [13:0]          i_flags,
  input  logic [15:0]          i_requester_id,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_aborted,
  output logic                 o_error,
  output logic                 o_egress_enable,
  input  logic                 i_egress_finished,
  output logic [7:0]           o_egress_command,
  output logic [13:0]          o_egress_flags,
  output logic [31:0]          o_egress_address,
  output logic [15:0]          o_egress_requester_id,
  output logic [7:0]           o_egress_tag,
  output logic [CNT_WIDTH-1:0] o_egress_size,
  output logic [15:0]          o_tlp_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CALC     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_FIN = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [7:0] PCIE_MWR_32B = 8'h40;
  localparam logic [7:0] PCIE_MRD_32B = 8'h00;

  // Chunk arithmetic width: wide enough for both the counter and a 1024-dword page.
  localparam int CW = (CNT_WIDTH > 11) ? CNT_WIDTH : 11;

  logic [2:0]           state;
  logic [31:0]          addr;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 cmd_write;
  logic                 abort_flag;
  logic [4:0]           tag;
  logic [10:0]          chunk_q;

  logic [10:0]          boundary_dw;
  logic [CW-1:0]        rem_w;
  logic [CW-1:0]        lim_w;
  logic [CW-1:0]        bnd_w;
  logic [CW-1:0]        chunk_w;
  logic                 start_ok;

  // Next chunk size: min(remaining, size limit, dwords left in the 4 KB page).
  always_comb begin
    boundary_dw = 11'd1024 - {1'b0, addr[11:2]};
    rem_w       = CW'(remaining);
    lim_w       = cmd_write ? CW'(MAX_PAYLOAD_DW) : CW'(MAX_READ_DW);
    bnd_w       = CW'(boundary_dw);
    chunk_w     = rem_w;
    if (lim_w < chunk_w) chunk_w = lim_w;
    if (bnd_w < chunk_w) chunk_w = bnd_w;
    start_ok    = (i_total_dwords != '0) && (i_base_address[1:0] == 2'b00);
  end

  // Transfer sequencer and builder handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= S_IDLE;
      addr                  <= '0;
      remaining             <= '0;
      cmd_write             <= 1'b0;
      abort_flag            <= 1'b0;
      tag                   <= '0;
      chunk_q               <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_aborted             <= 1'b0;
      o_error               <= 1'b0;
      o_egress_enable       <= 1'b0;
      o_egress_command      <= '0;
      o_egress_flags        <= '0;
      o_egress_address      <= '0;
      o_egress_requester_id <= '0;
      o_egress_tag          <= '0;
      o_egress_size         <= '0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      if ((state != S_IDLE) && i_abort) abort_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (!start_ok) begin
              o_error <= 1'b1;
            end else begin
              addr       <= i_base_address;
              remaining  <= i_total_dwords;
              cmd_write  <= i_cmd_write;
              abort_flag <= 1'b0;
              o_aborted  <= 1'b0;
              o_busy     <= 1'b1;
              state      <= S_CALC;
            end
          end
        end
        S_CALC: begin
          chunk_q               <= chunk_w[10:0];
          o_egress_size         <= chunk_w[CNT_WIDTH-1:0];
          o_egress_address      <= addr;
          o_egress_command      <= cmd_write ? PCIE_MWR_32B : PCIE_MRD_32B;
          o_egress_flags        <= i_flags;
          o_egress_requester_id <= i_requester_id;
          o_egress_tag          <= {3'b000, tag};
          state                 <= S_ISSUE;
        end
        S_ISSUE: begin
          o_egress_enable <= 1'b1;
          state           <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (i_egress_finished) begin
            o_egress_enable <= 1'b0;
            addr            <= addr + {19'd0, chunk_q, 2'b00};
            remaining       <= remaining - CNT_WIDTH'(chunk_q);
            if (!cmd_write) tag <= tag + 5'd1;
            state           <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // An abort arriving on this very edge still stops before the next chunk.
          if (!i_egress_finished) begin
            if ((remaining == '0) || abort_flag || i_abort) state <= S_DONE;
            else                                             state <= S_CALC;
          end
        end
        S_DONE: begin
          // Only a transfer with dwords left unissued counts as aborted.
          o_done    <= 1'b1;
          o_aborted <= abort_flag && (remaining != '0);
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PCIE_SPLIT_STATS_EN
  logic [15:0] tlp_count;

  // Per-transfer TLP counter, saturating, held after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_count <= '0;
    end else if ((state == S_IDLE) && i_start && start_ok) begin
      tlp_count <= '0;
    end else if ((state == S_WAIT_FIN) && i_egress_finished && (tlp_count != 16'hFFFF)) begin
      tlp_count <= tlp_count + 16'd1;
    end
  end

  assign o_tlp_count = tlp_count;
`else
  assign o_tlp_count = '0;
`endif

endmodule

// File: tb/tb_pcie_egress_splitter.sv
// Directed bench for pcie_egress_splitter: table of transfers with hand-computed
// chunk sizes/addresses, plus hand sequences for errors, reset and tag wrap.
module tb_pcie_egress_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_cmd_write;
  logic [31:0] i_base_address;
  logic [23:0] i_total_dwords;
  logic [13:0] i_flags;
  logic [15:0] i_requester_id;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic        o_error;
  logic        o_egress_enable;
  logic        i_egress_finished;
  logic [7:0]  o_egress_command;
  logic [13:0] o_egress_flags;
  logic [31:0] o_egress_address;
  logic [15:0] o_egress_requester_id;
  logic [7:0]  o_egress_tag;
  logic [23:0] o_egress_size;
  logic [15:0] o_tlp_count;

  localparam logic [7:0]  CMD_MWR = 8'h40;
  localparam logic [7:0]  CMD_MRD = 8'h00;
  localparam logic [13:0] FLAGS   = 14'h2A5A;
  localparam logic [15:0] RID     = 16'hBEEF;

  int checks = 0;
  int errors = 0;
  int exp_tag = 0;

  typedef struct packed {
    bit                 write;
    logic [31:0]        base;
    logic [23:0]        total;
    int                 abort_tlp;
    int                 exp_n;
    bit                 exp_ab;
    bit                 busy_start;
    bit                 chk_lat;
    logic [3:0][23:0]   size;
    logic [3:0][31:0]   addr;
  } xfer_t;

  pcie_egress_splitter #(
    .MAX_PAYLOAD_DW(32),
    .MAX_READ_DW(128),
    .CNT_WIDTH(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_cmd_write(i_cmd_write),
    .i_base_address(i_base_address),
    .i_total_dwords(i_total_dwords),
    .i_flags(i_flags),
    .i_requester_id(i_requester_id),
    .i_abort(i_abort),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_aborted(o_aborted),
    .o_error(o_error),
    .o_egress_enable(o_egress_enable),
    .i_egress_finished(i_egress_finished),
    .o_egress_command(o_egress_command),
    .o_egress_flags(o_egress_flags),
    .o_egress_address(o_egress_address),
    .o_egress_requester_id(o_egress_requester_id),
    .o_egress_tag(o_egress_tag),
    .o_egress_size(o_egress_size),
    .o_tlp_count(o_tlp_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic xfer_t mk(input bit w, input logic [31:0] base, input logic [23:0] total,
                               input int ab_tlp, input int n, input bit exab, input bit bs,
                               input bit lat, input logic [23:0] s0, input logic [23:0] s1,
                               input logic [23:0] s2, input logic [23:0] s3,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3);
    xfer_t v;
    v.write = w; v.base = base; v.total = total; v.abort_tlp = ab_tlp;
    v.exp_n = n; v.exp_ab = exab; v.busy_start = bs; v.chk_lat = lat;
    v.size[0] = s0; v.size[1] = s1; v.size[2] = s2; v.size[3] = s3;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
    return v;
  endfunction

  // Drives one transfer and plays the builder side of the handshake.
  task automatic run_xfer(input xfer_t v);
    int n;
    int cyc;
    bit fin;
    bit timed_out;
    i_cmd_write    = v.write;
    i_base_address = v.base;
    i_total_dwords = v.total;
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    if (v.chk_lat) begin
      chk("lat_busy", 32'(o_busy), 1);
      chk("lat_en_c1", 32'(o_egress_enable), 0);
      tick();
      chk("lat_en_c2", 32'(o_egress_enable), 0);
      tick();
      chk("lat_en_c3", 32'(o_egress_enable), 1);
    end
    n = 0; fin = 0; timed_out = 0;
    while (!fin) begin
      cyc = 0;
      while (!o_egress_enable && !o_done && cyc < 100) begin
        tick();
        cyc++;
      end
      if (cyc >= 100) begin
        timeout_fail("wait_enable_or_done");
        fin = 1; timed_out = 1;
      end else if (o_done) begin
        fin = 1;
      end else begin
        if (n < 4) begin
          chk("tlp_size", 32'(o_egress_size), 32'(v.size[n]));
          chk("tlp_addr", o_egress_address, v.addr[n]);
        end
        chk("tlp_cmd", 32'(o_egress_command), 32'(v.write ? CMD_MWR : CMD_MRD));
        chk("tlp_flags", 32'(o_egress_flags), 32'(FLAGS));
        chk("tlp_rid", 32'(o_egress_requester_id), 32'(RID));
        chk("tlp_tag", 32'(o_egress_tag), 32'(8'(exp_tag)));
        chk("tlp_busy", 32'(o_busy), 1);
        if (!v.write) exp_tag = (exp_tag + 1) % 32;
        if (n == v.abort_tlp) i_abort = 1'b1;
        if (v.busy_start && n == 0) begin
          i_total_dwords = '0;
          i_start = 1'b1;
        end
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        i_total_dwords = v.total;
        if (v.busy_start && n == 0) chk("busy_start_no_err", 32'(o_error), 0);
        chk("hold_en", 32'(o_egress_enable), 1);
        if (n < 4) chk("hold_addr", o_egress_address, v.addr[n]);
        i_egress_finished = 1'b1;
        tick();
        chk("en_drop", 32'(o_egress_enable), 0);
        tick();
        i_egress_finished = 1'b0;
        n++;
        if (n > 8) begin
          timeout_fail("too_many_tlps");
          fin = 1; timed_out = 1;
        end
      end
    end
    if (!timed_out) begin
      chk("tlp_num", 32'(n), 32'(v.exp_n));
      chk("done_aborted", 32'(o_aborted), 32'(v.exp_ab));
      chk("done_busy", 32'(o_busy), 0);
`ifdef PCIE_SPLIT_STATS_EN
      chk("tlp_count", 32'(o_tlp_count), 32'(v.exp_n));
`else
      chk("tlp_count_off", 32'(o_tlp_count), 0);
`endif
      tick();
      chk("done_pulse", 32'(o_done), 0);
      chk("aborted_hold", 32'(o_aborted), 32'(v.exp_ab));
    end
  endtask

  task automatic err_start(input string name, input logic [31:0] base, input logic [23:0] total);
    i_cmd_write    = 1'b1;
    i_base_address = base;
    i_total_dwords = total;
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    chk({name, "_err"}, 32'(o_error), 1);
    chk({name, "_busy"}, 32'(o_busy), 0);
    tick();
    chk({name, "_err_pulse"}, 32'(o_error), 0);
    for (int k = 0; k < 3; k++) begin
      chk({name, "_no_en"}, 32'(o_egress_enable), 0);
      chk({name, "_idle_busy"}, 32'(o_busy), 0);
      tick();
    end
  endtask

  xfer_t vec [7];

  initial begin
    int cyc;
    vec[0] = mk(1, 32'h0000_1000, 100, -1, 4, 0, 1, 1, 32, 32, 32, 4,
                32'h1000, 32'h1080, 32'h1100, 32'h1180);
    vec[1] = mk(1, 32'h0000_0FF0, 10, -1, 2, 0, 0, 0, 4, 6, 0, 0,
                32'h0FF0, 32'h1000, 0, 0);
    vec[2] = mk(0, 32'h0000_2000, 300, -1, 3, 0, 0, 0, 128, 128, 44, 0,
                32'h2000, 32'h2200, 32'h2400, 0);
    vec[3] = mk(0, 32'h0000_3F00, 200, -1, 3, 0, 0, 0, 64, 128, 8, 0,
                32'h3F00, 32'h4000, 32'h4200, 0);
    vec[4] = mk(1, 32'h0000_0000, 128, 1, 2, 1, 0, 0, 32, 32, 0, 0,
                32'h0000, 32'h0080, 0, 0);
    vec[5] = mk(1, 32'h0000_0000, 32, 0, 1, 0, 0, 0, 32, 0, 0, 0,
                32'h0000, 0, 0, 0);
    vec[6] = mk(1, 32'hFFFF_FFFC, 3, -1, 2, 0, 0, 0, 1, 2, 0, 0,
                32'hFFFF_FFFC, 32'h0000_0000, 0, 0);

    rst_n = 1'b0;
    i_start = 0; i_cmd_write = 0; i_base_address = '0; i_total_dwords = '0;
    i_flags = FLAGS; i_requester_id = RID; i_abort = 0; i_egress_finished = 0;
    tick();
    tick();
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_en", 32'(o_egress_enable), 0);
    chk("rst_addr", o_egress_address, 0);
    chk("rst_size", 32'(o_egress_size), 0);
    chk("rst_tlp_count", 32'(o_tlp_count), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_xfer(vec[i]);

    err_start("zero_len", 32'h0000_1000, 0);
    err_start("misalign", 32'h0000_1002, 16);

    // Reset while a TLP is enabled: outputs clear without a clock edge.
    i_cmd_write = 1'b1; i_base_address = 32'h0000_5000; i_total_dwords = 64;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (!o_egress_enable && cyc < 20) begin
      tick();
      cyc++;
    end
    if (cyc >= 20) timeout_fail("rst_mid_wait_en");
    chk("rst_mid_pre_en", 32'(o_egress_enable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'(o_egress_enable), 0);
    chk("rst_mid_busy", 32'(o_busy), 0);
    chk("rst_mid_cmd", 32'(o_egress_command), 0);
    chk("rst_mid_addr", o_egress_address, 0);
    chk("rst_mid_size", 32'(o_egress_size), 0);
    chk("rst_mid_tag", 32'(o_egress_tag), 0);
    chk("rst_mid_flags", 32'(o_egress_flags), 0);
    chk("rst_mid_rid", 32'(o_egress_requester_id), 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_tag = 0;
    tick();

    // 33 single-dword reads: tags 0..31 then wrap to 0.
    for (int i = 0; i < 33; i++) begin
      run_xfer(mk(0, 32'(i) << 8, 1, -1, 1, 0, 0, 0, 1, 0, 0, 0,
                  32'(i) << 8, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
